// File: rtl/seg_pkg.sv
// Shared types, segment table and constants for the seven-segment scan driver.
package seg_pkg;

    typedef struct packed {
        logic       dot;
        logic [3:0] hex;
    } seg_code_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] CS_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; element 0 (rightmost) is hex 0
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational {dot,hex} to active-low {dp,g,f,e,d,c,b,a} pattern.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  seg_code_t  code,
    output logic [7:0] seg
);

    assign seg = {~code.dot, hex_to_seg(code.hex)};

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 8-digit seven-segment scan driver with frame-aligned updates.
// Optional SEG_SCAN_DIM_EN adds i_bright for per-slot duty-cycle dimming.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int F_CLK     = 50000000,
    parameter int F_SCAN    = 1000,
    parameter int N_DIG     = 8,
    parameter int BLANK_CYC = 500
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [5*N_DIG-1:0] i_digit_data,
    input  logic [N_DIG-1:0]   i_digit_en,
    input  logic               i_load,
`ifdef SEG_SCAN_DIM_EN
    input  logic [3:0]         i_bright,
`endif
    output logic [7:0]         o_cs,
    output logic [7:0]         o_dig_sel,
    output logic               o_frame_done
);

    localparam int DWELL = F_CLK / F_SCAN;
    localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int PW    = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_DIG - 1);

    typedef enum logic {BLANK, SHOW} state_t;
    localparam state_t SLOT_START = (BLANK_CYC > 0) ? BLANK : SHOW;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      ptr_q;
    logic [5*N_DIG-1:0] stage_data, shadow_data;
    logic [N_DIG-1:0]   stage_en, shadow_en;
    logic               pending;
    logic [7:0]         cs_q, seg_q, cs_d, seg_d;
    logic               done_q;
    logic               wrap, fb, lit;
    seg_code_t          cur_code;
    logic [7:0]         cur_seg;

    assign wrap = (cnt_q == CNT_LAST);
    assign fb   = wrap && (ptr_q == PTR_LAST);

    assign cur_code = shadow_data[int'(ptr_q)*5 +: 5];

    seg_hex_decoder u_dec (
        .code (cur_code),
        .seg  (cur_seg)
    );

`ifdef SEG_SCAN_DIM_EN
    logic [3:0] bright_q;

    assign lit = (int'(cnt_q) - BLANK_CYC)
               < ((DWELL - BLANK_CYC) * (int'(bright_q) + 1)) / 16;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bright_q <= 4'hF;
        end else if (fb) begin
            bright_q <= i_bright;
        end
    end
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        if (wrap) begin
            state_d = SLOT_START;
        end else if (int'(cnt_q) + 1 == BLANK_CYC) begin
            state_d = SHOW;
        end
    end

    always_comb begin
        cs_d  = CS_OFF;
        seg_d = SEG_OFF;
        unique case (state_q)
            BLANK: ;
            SHOW: begin
                if (shadow_en[ptr_q] && lit) begin
                    cs_d  = ~(8'd1 << ptr_q);
                    seg_d = cur_seg;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            ptr_q   <= '0;
            state_q <= SLOT_START;
            cs_q    <= CS_OFF;
            seg_q   <= SEG_OFF;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
                ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            end
            state_q <= state_d;
            cs_q    <= cs_d;
            seg_q   <= seg_d;
            done_q  <= fb;
        end
    end

    // Digits come up enabled so a fresh reset shows zeros before any load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stage_data  <= '0;
            stage_en    <= '0;
            shadow_data <= '0;
            shadow_en   <= '1;
            pending     <= 1'b0;
        end else begin
            if (i_load) begin
                stage_data <= i_digit_data;
                stage_en   <= i_digit_en;
            end
            if (fb) begin
                pending <= 1'b0;
                if (i_load) begin
                    shadow_data <= i_digit_data;
                    shadow_en   <= i_digit_en;
                end else if (pending) begin
                    shadow_data <= stage_data;
                    shadow_en   <= stage_en;
                end
            end else if (i_load) begin
                pending <= 1'b1;
            end
        end
    end

    assign o_cs         = cs_q;
    assign o_dig_sel    = seg_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: DWELL=10, BLANK_CYC=2, N_DIG=8.
module tb_seg_scan_mux;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [39:0] data = '0;
    logic [7:0]  en   = 8'hFF;
    logic        load = 1'b0;
`ifdef SEG_SCAN_DIM_EN
    logic [3:0]  bright = 4'd7;
`endif
    logic [7:0]  cs, seg;
    logic        fd;

    seg_scan_mux #(
        .F_CLK     (100),
        .F_SCAN    (10),
        .N_DIG     (8),
        .BLANK_CYC (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_digit_data (data),
        .i_digit_en   (en),
        .i_load       (load),
`ifdef SEG_SCAN_DIM_EN
        .i_bright     (bright),
`endif
        .o_cs         (cs),
        .o_dig_sel    (seg),
        .o_frame_done (fd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          s;
        logic [16:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: what the display should hold
    int          s;
    logic [39:0] sh_d, st_d;
    logic [7:0]  sh_e, st_e;
    logic        pend;
    logic [3:0]  br_q;

    function automatic logic [7:0] seg_of(input logic [4:0] c);
        logic [6:0] p;
        case (c[3:0])
            4'h0: p = 7'h40;  4'h1: p = 7'h79;
            4'h2: p = 7'h24;  4'h3: p = 7'h30;
            4'h4: p = 7'h19;  4'h5: p = 7'h12;
            4'h6: p = 7'h02;  4'h7: p = 7'h78;
            4'h8: p = 7'h00;  4'h9: p = 7'h10;
            4'hA: p = 7'h08;  4'hB: p = 7'h03;
            4'hC: p = 7'h46;  4'hD: p = 7'h21;
            4'hE: p = 7'h06;  default: p = 7'h0E;
        endcase
        return {~c[4], p};
    endfunction

    task automatic check(input string name,
                         input logic [16:0] act,
                         input logic [16:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got cs=%h seg=%h fd=%b want cs=%h seg=%h fd=%b",
                     name, act[16:9], act[8:1], act[0],
                     want[16:9], want[8:1], want[0]);
        end
    endtask

    task automatic model_reset();
        sh_d = '0;
        sh_e = 8'hFF;
        st_d = '0;
        st_e = '0;
        pend = 1'b0;
        br_q = 4'hF;
        s    = 0;
    endtask

    // Predict the output after the next edge, then apply that edge to the model
    task automatic tick();
        int          cnt, ptr, lit;
        logic        fb, ld;
        logic [7:0]  ecs, eseg;
        logic [39:0] d;
        logic [7:0]  e;
        exp_t        x;
        cnt = s % 10;
        ptr = (s / 10) % 8;
        fb  = (s % 80 == 79);
`ifdef SEG_SCAN_DIM_EN
        lit = (8 * (int'(br_q) + 1)) / 16;
`else
        lit = 8;
`endif
        ecs  = 8'hFF;
        eseg = 8'hFF;
        if (cnt >= 2 && sh_e[ptr] && (cnt - 2) < lit) begin
            ecs  = ~(8'd1 << ptr);
            eseg = seg_of(sh_d[ptr*5 +: 5]);
        end
        ld = load;
        d  = data;
        e  = en;
        @(posedge clk);
        x.s = s;
        x.v = {ecs, eseg, fb};
        exp_q.push_back(x);
        if (fb) begin
            if (ld) begin
                sh_d = d;
                sh_e = e;
            end else if (pend) begin
                sh_d = st_d;
                sh_e = st_e;
            end
            pend = 1'b0;
`ifdef SEG_SCAN_DIM_EN
            br_q = bright;
`endif
        end else if (ld) begin
            pend = 1'b1;
        end
        if (ld) begin
            st_d = d;
            st_e = e;
        end
        s++;
        #1;
    endtask

    task automatic run_to(input int target);
        while (s < target) tick();
    endtask

    task automatic strobe();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset", {cs, seg, fd}, {8'hFF, 8'hFF, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", {cs, seg, fd}, {8'hFF, 8'hFF, 1'b0});
        rst = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check($sformatf("s%0d", x.s), {cs, seg, fd}, x.v);
            end
        end
    end

    initial begin : stim
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {cs, seg, fd}, {8'hFF, 8'hFF, 1'b0});
        rst = 1'b0;
        run_to(25);
        // digit 3 = dot + '8', visible only from frame 1
        data = '0;
        data[19:15] = 5'b11000;
        en = 8'hFF;
        strobe();
        run_to(100);
        en = 8'hFB;
        strobe();
        // load exactly on the frame boundary: digit 0 = '1'
        run_to(239);
        data = '0;
        data[4:0] = 5'b00001;
        en = 8'hFF;
        strobe();
        run_to(372);
        do_reset();
        run_to(100);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
